// File: rtl/ssm_pkg.sv
// ssm_pkg: shared definitions for the SSM control path.
//   - Opcode constants for the two instructions handled locally (NOP, HALT).
//   - Bit positions of the decoded instruction fields.
//   - Dispatch FSM state encoding.
//   - Helper that tells which execution FSM owns an opcode.
package ssm_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int P1_HI  = 27;
  localparam int P1_LO  = 22;
  localparam int P2_HI  = 21;
  localparam int P2_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DECODE,
    START,
    WAIT_DONE,
    HALTED,
    ERROR
  } dispatch_state_e;

  // Opcodes 8..14 belong to the immediate ALU, 1..7 to the register ALU;
  // NOP and HALT never reach an execution FSM, so the MSB alone decides.
  function automatic logic is_imm_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// dispatch_watchdog: clearable up-counter bounding the wait for an
// execution FSM's done.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, count returns to 0
//   clr_i  - synchronous clear (priority over en_i)
//   en_i   - count enable
//   tc_o   - high while the count equals DONE_TIMEOUT-1
module dispatch_watchdog #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(DONE_TIMEOUT - 1));

  // Holds at terminal count so the counter can never wrap back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instruction_dispatch_fsm.sv
// instruction_dispatch_fsm: fetches instructions from a synchronous memory,
// decodes them and hands each one to exactly one execution FSM.
// Ports:
//   clock, reset            - clock and asynchronous active-high reset
//   run                     - level enable for fetching
//   imem_addr/rd_en/rdata   - synchronous instruction memory (1-cycle latency)
//   opcode/param1/param2/immediate - decoded fields of the current instruction
//   reg_alu_start/done      - handshake with the register ALU FSM
//   imm_alu_start/done      - handshake with the immediate ALU FSM
//   pc                      - program counter (wraps modulo 2^PC_WIDTH)
//   busy/halted/error       - status
module instruction_dispatch_fsm
  import ssm_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd_en,
  input  logic [31:0]         imem_rdata,
  output logic [3:0]          opcode,
  output logic [5:0]          param1,
  output logic [5:0]          param2,
  output logic [15:0]         immediate,
  output logic                reg_alu_start,
  output logic                imm_alu_start,
  input  logic                reg_alu_done,
  input  logic                imm_alu_done,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                error
);

  dispatch_state_e     state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                rd_en_q, reg_start_q, imm_start_q;
  logic                wd_clr, wd_en, wd_tc;
  logic                sel_done;

  dispatch_watchdog #(
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  // Fields come straight from the instruction register, so they stay put
  // from one LATCH to the next.
  assign opcode    = ir_q[OPC_HI:OPC_LO];
  assign param1    = ir_q[P1_HI:P1_LO];
  assign param2    = ir_q[P2_HI:P2_LO];
  assign immediate = ir_q[IMM_HI:IMM_LO];

  // Only the done of the FSM that owns the current opcode is listened to.
  assign sel_done = is_imm_op(opcode) ? imm_alu_done : reg_alu_done;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  state_d = LATCH;
      LATCH: begin
        ir_d    = imem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode == OP_NOP) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = run ? FETCH : IDLE;
        end else if (opcode == OP_HALT) begin
          state_d = HALTED;
        end else begin
          state_d = START;
        end
      end
      START: begin
        wd_clr  = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_en = 1'b1;
        // done is checked first so it wins a same-cycle timeout.
        if (sel_done) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = run ? FETCH : IDLE;
        end else if (wd_tc) begin
          state_d = ERROR;
        end
      end
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      rd_en_q     <= 1'b0;
      reg_start_q <= 1'b0;
      imm_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      // Strobes are flopped alongside the state they belong to, so they are
      // high exactly during FETCH / START.
      rd_en_q     <= (state_d == FETCH);
      reg_start_q <= (state_d == START) && !is_imm_op(ir_d[OPC_HI:OPC_LO]);
      imm_start_q <= (state_d == START) &&  is_imm_op(ir_d[OPC_HI:OPC_LO]);
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign imem_rd_en    = rd_en_q;
  assign reg_alu_start = reg_start_q;
  assign imm_alu_start = imm_start_q;
  assign busy          = (state_q != IDLE) && (state_q != HALTED) && (state_q != ERROR);
  assign halted        = (state_q == HALTED);
  assign error         = (state_q == ERROR);

endmodule

// File: tb/tb_instruction_dispatch_fsm.sv
module tb_instruction_dispatch_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic        run2  = 1'b0;
  logic        reg_alu_done = 1'b0;
  logic        imm_alu_done = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] mem [0:255];

  logic [7:0]  imem_addr, pc;
  logic        imem_rd_en, reg_alu_start, imm_alu_start, busy, halted, error;
  logic [3:0]  opcode;
  logic [5:0]  param1, param2;
  logic [15:0] immediate;

  logic [1:0]  imem_addr2, pc2;
  logic        imem_rd_en2, reg_alu_start2, imm_alu_start2, busy2, halted2, error2;
  logic [3:0]  opcode2;
  logic [5:0]  param1_2, param2_2;
  logic [15:0] immediate2;

  int n_chk  = 0;
  int n_pass = 0;
  int n_reg_start = 0;
  int n_imm_start = 0;
  int n_rd = 0;
  int snap_reg, snap_imm, snap_rd;

  always #5 clock = ~clock;

  instruction_dispatch_fsm #(.PC_WIDTH(8), .DONE_TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .opcode(opcode), .param1(param1), .param2(param2), .immediate(immediate),
    .reg_alu_start(reg_alu_start), .imm_alu_start(imm_alu_start),
    .reg_alu_done(reg_alu_done), .imm_alu_done(imm_alu_done),
    .pc(pc), .busy(busy), .halted(halted), .error(error)
  );

  // Narrow-PC instance fed an all-NOP program.
  instruction_dispatch_fsm #(.PC_WIDTH(2), .DONE_TIMEOUT(64)) dut2 (
    .clock(clock), .reset(reset), .run(run2),
    .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2), .imem_rdata(32'h0),
    .opcode(opcode2), .param1(param1_2), .param2(param2_2), .immediate(immediate2),
    .reg_alu_start(reg_alu_start2), .imm_alu_start(imm_alu_start2),
    .reg_alu_done(1'b0), .imm_alu_done(1'b0),
    .pc(pc2), .busy(busy2), .halted(halted2), .error(error2)
  );

  always @(posedge clock)
    if (imem_rd_en) imem_rdata <= mem[imem_addr];

  always @(negedge clock) begin
    if (reg_alu_start) n_reg_start++;
    if (imm_alu_start) n_imm_start++;
    if (imem_rd_en)    n_rd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000;
    mem[0] = w0;
    mem[1] = w1;
  endtask

  // Assert reset between edges, then release it just after an edge with run
  // already set; the next edge is the IDLE->FETCH edge.
  task automatic do_reset(input logic run_val);
    #2 reset = 1'b1;
    reg_alu_done = 1'b0;
    imm_alu_done = 1'b0;
    run = run_val;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    load_prog(32'h0, 32'h0);
    do_reset(1'b0);

    // Reset values
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_imm", 32'(immediate), 32'h0);
    chk("rst_status", {busy, halted, error, imem_rd_en, reg_alu_start, imm_alu_start}, 32'h0);
    tick(2);
    chk("idle_no_run", {busy, imem_rd_en}, 32'h0);

    // Register-ALU instruction, done three cycles after the pulse
    load_prog(32'h1042_0000, 32'hF000_0000);
    do_reset(1'b1);
    snap_reg = n_reg_start;
    tick(1);
    chk("t1_fetch_rd", 32'(imem_rd_en), 32'h1);
    chk("t1_fetch_busy", 32'(busy), 32'h1);
    tick(2);
    chk("t1_decode_fields", {opcode, param1, param2}, {16'h0, 4'h1, 6'd1, 6'd2});
    tick(1);
    chk("t1_start", {reg_alu_start, imm_alu_start}, 32'h2);
    tick(3);
    chk("t1_start_gone", 32'(reg_alu_start), 32'h0);
    chk("t1_fields_stable", {opcode, param1, param2}, {16'h0, 4'h1, 6'd1, 6'd2});
    reg_alu_done = 1'b1;
    tick(1);
    reg_alu_done = 1'b0;
    chk("t1_pc_inc", 32'(pc), 32'h1);
    chk("t1_refetch", 32'(imem_rd_en), 32'h1);
    chk("t1_one_pulse", 32'(n_reg_start - snap_reg), 32'h1);

    // Immediate-ALU instruction, stray reg done, run dropped mid-instruction
    load_prog(32'h9040_00FF, 32'hF000_0000);
    do_reset(1'b1);
    snap_reg = n_reg_start;
    snap_imm = n_imm_start;
    tick(3);
    chk("t2_immediate", 32'(immediate), 32'h0000_00FF);
    chk("t2_opcode", 32'(opcode), 32'h9);
    tick(1);
    chk("t2_start", {reg_alu_start, imm_alu_start}, 32'h1);
    tick(1);
    run = 1'b0;
    reg_alu_done = 1'b1;
    tick(1);
    chk("t2_stray_ignored", {busy, pc}, {23'h0, 1'b1, 8'h00});
    reg_alu_done = 1'b0;
    imm_alu_done = 1'b1;
    tick(1);
    imm_alu_done = 1'b0;
    chk("t2_idle_pc", {busy, imem_rd_en, pc}, {22'h0, 1'b0, 1'b0, 8'h01});
    tick(2);
    chk("t2_pulse_counts", {n_reg_start - snap_reg, n_imm_start - snap_imm}, {16'd0, 16'd1});

    // NOP then HALT
    load_prog(32'h0000_0000, 32'hF000_0000);
    do_reset(1'b1);
    tick(4);
    chk("t3_nop_pc", {imem_rd_en, pc}, {23'h0, 1'b1, 8'h01});
    tick(3);
    chk("t3_halted", {halted, busy, error, pc}, {21'h0, 3'b100, 8'h01});
    snap_rd = n_rd;
    tick(5);
    chk("t3_no_fetch", {imem_rd_en, 31'(n_rd - snap_rd)}, 32'h0);

    // Immediate op whose done never arrives
    load_prog(32'h8000_0000, 32'hF000_0000);
    do_reset(1'b1);
    tick(5);
    tick(63);
    chk("t4_pre_timeout", {error, busy}, 32'h1);
    tick(1);
    chk("t4_error", {error, busy}, 32'h2);
    tick(3);
    chk("t4_error_sticky", {error, busy, imem_rd_en}, 32'h4);

    // done in the very cycle the watchdog expires
    do_reset(1'b1);
    tick(68);
    imm_alu_done = 1'b1;
    tick(1);
    imm_alu_done = 1'b0;
    chk("t4b_done_wins", {error, imem_rd_en, pc}, {22'h0, 1'b0, 1'b1, 8'h01});

    // Narrow PC wraps 3 -> 0
    run = 1'b0;
    #2 reset = 1'b1;
    run2 = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("t5_pc3", {imem_rd_en2, pc2}, {29'h0, 1'b1, 2'd3});
    tick(3);
    chk("t5_wrap", {imem_rd_en2, pc2}, {29'h0, 1'b1, 2'd0});
    tick(3);
    chk("t5_continue", {imem_rd_en2, pc2}, {29'h0, 1'b1, 2'd1});
    run2 = 1'b0;

    // Reset mid WAIT_DONE
    load_prog(32'h0000_0000, 32'h1042_0000);
    do_reset(1'b1);
    tick(8);
    chk("t6_in_wait", {busy, opcode, pc}, {19'h0, 1'b1, 4'h1, 8'h01});
    snap_reg = n_reg_start;
    #3 reset = 1'b1;
    #1;
    chk("t6_async_rst", {busy, reg_alu_start, imem_rd_en, opcode, param1, param2, pc},
        32'h0);
    tick(3);
    chk("t6_no_pulse", 32'(n_reg_start - snap_reg), 32'h0);
    reset = 1'b0;
    tick(1);
    chk("t6_restart", {imem_rd_en, imem_addr}, {23'h0, 1'b1, 8'h00});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instruction_dispatch_fsm.md
# instruction_dispatch_fsm

Upstream control stage of the SSM datapath:
- Fetches 32-bit instruction words from a synchronous instruction memory and decodes them into opcode, param1, param2 and immediate fields.
- Pulses `FSM_start` to exactly one execution FSM (register ALU or immediate ALU), waits for its `done`, then advances the program counter.
- Owns the PC, a HALT instruction and a done-watchdog. Every execution FSM in the design is started only from this block.

## Interface
Parameters:
- PC_WIDTH, 8, instruction memory address width; the PC wraps modulo 2^PC_WIDTH.
- DONE_TIMEOUT, 64, maximum cycles spent in WAIT_DONE before ERROR.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- run  in  1  level enable; fetch begins or continues while high.
- imem_addr  out  PC_WIDTH  equals pc.
- imem_rd_en  out  1  read strobe; high only in FETCH.
- imem_rdata  in  32  read data, valid the cycle after imem_rd_en.
- opcode  out  4  ir[31:28].
- param1  out  6  ir[27:22].
- param2  out  6  ir[21:16].
- immediate  out  16  ir[15:0].
- reg_alu_start  out  1  one-cycle start pulse to the register ALU FSM.
- imm_alu_start  out  1  one-cycle start pulse to the immediate ALU FSM.
- reg_alu_done  in  1  done from the register ALU FSM.
- imm_alu_done  in  1  done from the immediate ALU FSM.
- pc  out  PC_WIDTH  current program counter.
- busy  out  1  high in every state except IDLE, HALTED and ERROR.
- halted  out  1  high in HALTED.
- error  out  1  high in ERROR.

## Operation
Reset values:
- pc=0, ir=0, so all decoded fields are 0.
- All start pulses, imem_rd_en, busy, halted and error are 0.
- State is IDLE; watchdog count is 0.

Decode rules:
- 4'b0000 is NOP.
- 4'b1111 is HALT.
- 4'b0001–4'b0111 go to the register ALU.
- 4'b1000–4'b1110 go to the immediate ALU.
- The opcode is forwarded unchanged; the downstream FSM derives alu_control from it.

States and transitions:
- IDLE: when run=1, go to FETCH.
- FETCH: imem_rd_en=1 for one cycle; go to LATCH.
- LATCH: ir <= imem_rdata; go to DECODE.
- DECODE:
  - NOP: pc <= pc+1, then FETCH if run=1, else IDLE.
  - HALT: go to HALTED; pc is not incremented.
  - Otherwise: go to START.
- START: assert the selected start output for exactly one cycle; clear the watchdog; go to WAIT_DONE.
- WAIT_DONE:
  - On done from the selected FSM: pc <= pc+1, then FETCH if run=1, else IDLE.
  - On the watchdog reaching DONE_TIMEOUT-1 with no done: go to ERROR.
- HALTED, ERROR: terminal; exited only by reset.

Boundary rules:
- Decoded fields stay stable from LATCH until the next LATCH, including the whole WAIT_DONE period.
- done from the non-selected FSM is ignored; so is any done outside WAIT_DONE.
- run falling mid-instruction does not abort. The current instruction completes, then the FSM returns to IDLE with pc already incremented.
- When done and timeout occur in the same cycle, done wins.
- PC at 2^PC_WIDTH-1 increments to 0; there is no flag.
- Reset in any state, including mid WAIT_DONE, returns to reset values in the same cycle. No start pulse is issued afterwards until a new FETCH.

## Timing
- FETCH→LATCH→DECODE→START→WAIT_DONE occupy one cycle each up to WAIT_DONE.
- If done arrives in the k-th WAIT_DONE cycle (k≥1), the next FETCH comes 4+k cycles after the previous FETCH.
- A NOP takes 3 cycles, FETCH to FETCH.
- The start pulse is registered. It is high during the START cycle and the execution FSM samples it on the following edge.
- The ERROR transition occurs after exactly DONE_TIMEOUT cycles in WAIT_DONE.

## Structure
- Shared package ssm_pkg:
  - Opcode constants OP_NOP=4'h0 and OP_HALT=4'hF.
  - Field bit positions.
  - The dispatch state enum: IDLE, FETCH, LATCH, DECODE, START, WAIT_DONE, HALTED, ERROR.
- One sub-module, dispatch_watchdog:
  - Clearable up-counter with a terminal-count output.
  - Parameterised by DONE_TIMEOUT; width $clog2(DONE_TIMEOUT).

## Test plan
- imem[0]=32'h1042_0000 (opcode 1, p1=1, p2=2), run=1, reg_alu_done raised 3 cycles after the pulse. Required: a single reg_alu_start pulse, opcode=1, param1=1, param2=2, then pc=1 and a new FETCH.
- imem[0]=32'h9040_00FF. Required: imm_alu_start pulses, immediate=16'h00FF, reg_alu_start never rises; a stray reg_alu_done during WAIT_DONE is ignored.
- imem[0]=NOP, imem[1]=32'hF000_0000. Required: pc goes 0→1, halted=1 with pc=1, imem_rd_en stays 0 afterwards.
- Immediate op whose done never arrives. Required: error=1 exactly 64 cycles after entering WAIT_DONE; busy=0.
- PC_WIDTH=2, four NOPs. Required: pc wraps 3→0 and fetching continues.
- reset pulsed mid WAIT_DONE. Required: all outputs at reset values asynchronously; with run=1 after release, fetch restarts from pc=0.
